strip_frame_sequencer: RTL and testbench

- Parametrised frame sequencer for a serial addressable-LED strip.
- Generates one RGB value per pixel, in order, and paces them with the pixel encoder's `done` handshake.
- Asserts `latch` after the last pixel, then holds it until both the encoder latch period and the frame timer have completed.
- Replaces the fixed 64-pixel / 60 fps ramp controller with configurable strip length, channel width, frame period and frame-animated modes; sits between keyboard/RGB control and the gamma/encoder stage.

---
 rtl/strip_frame_sequencer.sv | 134 +++++++++++++
 tb/tb_strip_frame_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/strip_frame_sequencer.sv
// strip_frame_sequencer: paced per-pixel RGB generator with latch/frame-timer handshake for an LED strip.
// Define SEQ_BRIGHTNESS_EN to add a per-frame brightness scaler on every colour channel.
module strip_frame_sequencer #(
    parameter int NUM_PIXELS   = 64,
    parameter int CW           = 8,
    parameter int FRAME_CYCLES = 166667,
    parameter int STEP         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    anim_sel,
    input  logic [CW-1:0]                 base_r,
    input  logic [CW-1:0]                 base_g,
    input  logic [CW-1:0]                 base_b,
`ifdef SEQ_BRIGHTNESS_EN
    input  logic [CW-1:0]                 brightness,
`endif
    input  logic                          done,
    output logic [CW-1:0]                 r,
    output logic [CW-1:0]                 g,
    output logic [CW-1:0]                 b,
    output logic                          latch,
    output logic [$clog2(NUM_PIXELS)-1:0] pixel_idx,
    output logic                          frame_start,
    output logic                          overrun
);
    localparam int PW = $clog2(NUM_PIXELS);
    localparam int TW = $clog2(FRAME_CYCLES + 1);

    typedef enum logic {LATCH, SHIFT} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pending_q, pending_d, latch_ok_q, latch_ok_d, first_q, first_d;
    logic          fs_q, fs_d, ovr_q, ovr_d;
    logic [CW-1:0] off_q, off_d, r_q, r_d, g_q, g_d, b_q, b_d;
    logic [3:0]    mode_q, mode_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          tick, start, adv, load, lit, ramp_r, ramp_g, ramp_b, solid;
    logic [CW-1:0] v, cr, cg, cb;
`ifdef SEQ_BRIGHTNESS_EN
    logic [CW-1:0] br_q, br_d;

    function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [CW-1:0] k);
        logic [2*CW-1:0] p;
        p = {{CW{1'b0}}, c} * {{CW{1'b0}}, k};
        return CW'(p >> CW);
    endfunction
`endif

    always_comb begin
        tick       = timer_q == TW'(FRAME_CYCLES - 1);
        timer_d    = tick ? '0 : timer_q + TW'(1);
        start      = state_q == LATCH && (latch_ok_q || done) && (pending_q || tick);
        adv        = state_q == SHIFT && done && pix_q != PW'(NUM_PIXELS - 1);
        load       = start || adv;
        state_d    = start ? SHIFT : (state_q == SHIFT && done && !adv) ? LATCH : state_q;
        pending_d  = !start && (pending_q || tick);
        latch_ok_d = !start && (latch_ok_q || (state_q == LATCH && done));
        first_d    = first_q && !start;
        // The first frame after reset keeps offset 0; later frames scroll by STEP.
        off_d      = (start && !first_q) ? off_q + CW'(STEP) : off_q;
        mode_d     = start ? anim_sel : mode_q;
        pix_d      = start ? '0 : adv ? pix_q + PW'(1) : pix_q;
        fs_d       = start;
        ovr_d      = ovr_q || (state_q == SHIFT && tick);
        // Colour is computed from next-state values so it lands with the pixel index.
        v      = CW'(32'(pix_d) * 32'(STEP) + ((mode_d == 4'd6) ? 32'(off_d) : 32'd0));
        lit    = (mode_d == 4'd5) && ((32'(off_d) / 32'(STEP)) % 32'(NUM_PIXELS) == 32'(pix_d));
        ramp_r = mode_d inside {4'd0, 4'd1, 4'd6};
        ramp_g = mode_d inside {4'd0, 4'd2, 4'd6} || mode_d >= 4'd7;
        ramp_b = mode_d inside {4'd0, 4'd3, 4'd6};
        solid  = mode_d == 4'd4 || lit;
        cr     = ramp_r ? v : solid ? base_r : '0;
        cg     = ramp_g ? v : solid ? base_g : '0;
        cb     = ramp_b ? v : solid ? base_b : '0;
`ifdef SEQ_BRIGHTNESS_EN
        br_d   = start ? brightness : br_q;
        r_d    = load ? scale(cr, br_d) : r_q;
        g_d    = load ? scale(cg, br_d) : g_q;
        b_d    = load ? scale(cb, br_d) : b_q;
`else
        r_d    = load ? cr : r_q;
        g_d    = load ? cg : g_q;
        b_d    = load ? cb : b_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= LATCH;
            timer_q    <= '0;
            pending_q  <= 1'b1;
            latch_ok_q <= 1'b0;
            first_q    <= 1'b1;
            fs_q       <= 1'b0;
            ovr_q      <= 1'b0;
            off_q      <= '0;
            mode_q     <= '0;
            pix_q      <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
`ifdef SEQ_BRIGHTNESS_EN
            br_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            latch_ok_q <= latch_ok_d;
            first_q    <= first_d;
            fs_q       <= fs_d;
            ovr_q      <= ovr_d;
            off_q      <= off_d;
            mode_q     <= mode_d;
            pix_q      <= pix_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
`ifdef SEQ_BRIGHTNESS_EN
            br_q       <= br_d;
`endif
        end
    end

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign latch       = state_q == LATCH;
    assign pixel_idx   = pix_q;
    assign frame_start = fs_q;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_strip_frame_sequencer.sv
// tb_strip_frame_sequencer: table, hand-written and randomized frame checks against a frame-level model.
module tb_strip_frame_sequencer;
    localparam int NP = 4, FC = 100, ST = 4;

    typedef struct packed {
        logic [3:0]  sel;
        logic [7:0]  br, bg, bb;
        logic [31:0] er, eg, eb;
    } vec_t;

    logic       clk = 0, reset = 0, done = 0;
    logic [3:0] anim_sel = 0;
    logic [7:0] base_r = 0, base_g = 0, base_b = 0;
    logic [7:0] r, g, b, r2, g2, b2;
    logic       latch, latch2, frame_start, fs2, overrun, ovr2;
    logic [1:0] pixel_idx, pidx2;
    int         edge_n = 0, rst_edge = 0, last_dec = 0, frame_k = 0, fs_edge = 0, d_edge = 0;
    int         vecs = 0, errs = 0, cap_r2 = 0;
    int         cap_r[NP], cap_g[NP], cap_b[NP];
    bit         first_pend = 1, exp_ovr = 0;
    vec_t       tv[9];

    strip_frame_sequencer #(.NUM_PIXELS(NP), .CW(8), .FRAME_CYCLES(FC), .STEP(ST)) dut (
        .clk(clk), .reset(reset), .anim_sel(anim_sel), .base_r(base_r), .base_g(base_g),
        .base_b(base_b), .done(done), .r(r), .g(g), .b(b), .latch(latch),
        .pixel_idx(pixel_idx), .frame_start(frame_start), .overrun(overrun));

    strip_frame_sequencer #(.NUM_PIXELS(NP), .CW(8), .FRAME_CYCLES(FC), .STEP(100)) dut2 (
        .clk(clk), .reset(reset), .anim_sel(anim_sel), .base_r(base_r), .base_g(base_g),
        .base_b(base_b), .done(done), .r(r2), .g(g2), .b(b2), .latch(latch2),
        .pixel_idx(pidx2), .frame_start(fs2), .overrun(ovr2));

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    // First timer wrap strictly after edge e (timer restarts at 0 after the last reset edge).
    function automatic int next_tick(input int e);
        return rst_edge + FC * ((e - rst_edge) / FC + 1);
    endfunction

    function automatic logic [23:0] model(input int mode, input int idx, input int fk, input int step);
        int off, v;
        bit lit;
        off = (fk * step) % 256;
        v   = (idx * step + (mode == 6 ? off : 0)) % 256;
        lit = ((off / step) % NP) == idx;
        if (mode == 0 || mode == 6) return {v[7:0], v[7:0], v[7:0]};
        if (mode == 1) return {v[7:0], 16'h0};
        if (mode == 3) return {16'h0, v[7:0]};
        if (mode == 4) return {base_r, base_g, base_b};
        if (mode == 5) return lit ? {base_r, base_g, base_b} : 24'h0;
        return {8'h0, v[7:0], 8'h0};
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", n, act, exp, edge_n);
        end
    endtask

    task automatic pulse(output int e);
        done = 1;
        @(negedge clk);
        done = 0;
        e = edge_n;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 0;
        done  = 0;
        repeat (2) @(negedge clk);
        rst_edge = edge_n; last_dec = edge_n; first_pend = 1; exp_ovr = 0; frame_k = 0;
        reset = 1;
        chk("rst_latch", int'(latch), 1);
        chk("rst_rgb", int'({r, g, b}), 0);
        chk("rst_idx", int'(pixel_idx), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_overrun", int'(overrun), 0);
    endtask

    // Issue the latch done, then shift one full frame; pixel colours are captured in cap_*.
    task automatic run_frame(input logic [3:0] sel, input logic [3:0] mid, input int pgap, input int lgap);
        int dd, dec, e, w, q;
        anim_sel = sel;
        repeat (lgap) @(negedge clk);
        pulse(dd);
        dec = (first_pend || next_tick(last_dec) <= dd) ? dd : next_tick(last_dec);
        w = 0;
        while (!frame_start && w < 3 * FC) begin
            @(negedge clk);
            w++;
        end
        fs_edge = edge_n; d_edge = dd;
        chk("frame_start_edge", edge_n, dec);
        chk("start_latch", int'(latch), 0);
        chk("start_idx", int'(pixel_idx), 0);
        chk("px0_rgb", int'({r, g, b}), int'(model(int'(sel), 0, frame_k, ST)));
        cap_r[0] = int'(r); cap_g[0] = int'(g); cap_b[0] = int'(b);
        last_dec = dec; first_pend = 0;
        e = dd;
        for (int p = 0; p < NP; p++) begin
            if (p == 1) anim_sel = mid;
            repeat (pgap) @(negedge clk);
            pulse(e);
            if (p == 0) chk("fs_width", int'(frame_start), 0);
            q = (p < NP - 1) ? p + 1 : NP - 1;
            chk("px_idx", int'(pixel_idx), q);
            chk("px_latch", int'(latch), int'(p == NP - 1));
            chk("px_rgb", int'({r, g, b}), int'(model(int'(sel), q, frame_k, ST)));
            cap_r[q] = int'(r); cap_g[q] = int'(g); cap_b[q] = int'(b);
        end
        cap_r2 = int'(r2);
        if (next_tick(dec) <= e) exp_ovr = 1;
        chk("overrun", int'(overrun), int'(exp_ovr));
        frame_k++;
    endtask

    initial begin
        int e, w, lit, prev;
        tv[0] = '{4'd0, 8'd0,   8'd0,  8'd0,  32'h0C080400, 32'h0C080400, 32'h0C080400};
        tv[1] = '{4'd1, 8'd1,   8'd2,  8'd3,  32'h0C080400, 32'h0,        32'h0};
        tv[2] = '{4'd2, 8'd1,   8'd2,  8'd3,  32'h0,        32'h0C080400, 32'h0};
        tv[3] = '{4'd3, 8'd1,   8'd2,  8'd3,  32'h0,        32'h0,        32'h0C080400};
        tv[4] = '{4'd4, 8'd10,  8'd20, 8'd30, 32'h0A0A0A0A, 32'h14141414, 32'h1E1E1E1E};
        tv[5] = '{4'd5, 8'd255, 8'd0,  8'd0,  32'h0000FF00, 32'h0,        32'h0};
        tv[6] = '{4'd6, 8'd0,   8'd0,  8'd0,  32'h24201C18, 32'h24201C18, 32'h24201C18};
        tv[7] = '{4'd9, 8'd0,   8'd0,  8'd0,  32'h0,        32'h0C080400, 32'h0};
        tv[8] = '{4'd6, 8'd0,   8'd0,  8'd0,  32'h2C282420, 32'h2C282420, 32'h2C282420};

        do_reset();
        prev = 0;
        for (int k = 0; k < 9; k++) begin
            base_r = tv[k].br; base_g = tv[k].bg; base_b = tv[k].bb;
            run_frame(tv[k].sel, tv[k].sel, 10, 5);
            if (k > 0) chk("frame_on_wrap", fs_edge - rst_edge, FC * k);
            if (k > 1) chk("frame_period", fs_edge - prev, FC);
            prev = fs_edge;
            for (int p = 0; p < NP; p++) begin
                chk("tbl_r", cap_r[p], int'(tv[k].er[8*p +: 8]));
                chk("tbl_g", cap_g[p], int'(tv[k].eg[8*p +: 8]));
                chk("tbl_b", cap_b[p], int'(tv[k].eb[8*p +: 8]));
            end
        end

        do_reset();
        for (int k = 0; k < 3; k++) begin
            run_frame(4'd6, 4'd6, 3, 2);
            chk("m6_px0", cap_r[0], 4 * k);
            chk("m6_px3", cap_r[3], 12 + 4 * k);
            if (k == 0) chk("step100_px3", cap_r2, 44);
        end

        do_reset();
        base_r = 8'd255; base_g = 8'd0; base_b = 8'd0;
        for (int k = 0; k < 5; k++) begin
            run_frame(4'd5, 4'd5, 2, 2);
            lit = -1;
            for (int p = 0; p < NP; p++) if (cap_r[p] == 255) lit = p;
            chk("chase_pos", lit, k % NP);
        end

        do_reset();
        run_frame(4'd1, 4'd3, 4, 2);
        chk("sel_hold_r3", cap_r[3], 12);
        chk("sel_hold_b3", cap_b[3], 0);
        run_frame(4'd3, 4'd3, 4, 2);
        chk("sel_next_b2", cap_b[2], 8);
        chk("sel_next_r2", cap_r[2], 0);

        run_frame(4'd0, 4'd0, 150, 3);
        chk("ovr_set", int'(overrun), 1);
        run_frame(4'd0, 4'd0, 5, 3);
        chk("start_after_latch", fs_edge - d_edge, 0);
        chk("ovr_sticky", int'(overrun), 1);

        anim_sel = 4'd2;
        pulse(e);
        w = 0;
        while (!frame_start && w < 3 * FC) begin
            @(negedge clk);
            w++;
        end
        chk("pre_rst_start", int'(frame_start), 1);
        pulse(e);
        chk("pre_rst_g", int'(g), 4);
        do_reset();
        run_frame(4'd0, 4'd0, 3, 4);
        chk("post_rst_px0", cap_r[0] + cap_g[0] + cap_b[0], 0);

        for (int k = 0; k < 40; k++) begin
            base_r = 8'($urandom_range(0, 255));
            base_g = 8'($urandom_range(0, 255));
            base_b = 8'($urandom_range(0, 255));
            run_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 35)), int'($urandom_range(0, 30)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
